// File: rtl/traffic_light_ctrl_param_if.sv
// Signal bundle between the junction controller and its environment:
// demand/mode inputs and the four light groups plus status.
interface traffic_light_ctrl_param_if;
    logic       side_req;
    logic       flash_en;
    logic [2:0] light_M1;
    logic [2:0] light_M2;
    logic [2:0] light_MT;
    logic [2:0] light_S;
    logic [2:0] phase;
    logic       side_pend;

    modport master (
        output side_req,
        output flash_en,
        input  light_M1,
        input  light_M2,
        input  light_MT,
        input  light_S,
        input  phase,
        input  side_pend
    );

    modport slave (
        input  side_req,
        input  flash_en,
        output light_M1,
        output light_M2,
        output light_MT,
        output light_S,
        output phase,
        output side_pend
    );
endinterface

// File: rtl/traffic_light_ctrl_param.sv
// Parametrised four-approach junction controller with all-red clearance,
// latched side-road demand with optional skip, and night flash mode.
module traffic_light_ctrl_param #(
    parameter int TICK_DIV  = 1,
    parameter int TW        = 8,
    parameter int T_MAIN    = 7,
    parameter int T_TURN    = 2,
    parameter int T_SIDE    = 3,
    parameter int T_YEL     = 2,
    parameter int T_ALLRED  = 1,
    parameter int SKIP_SIDE = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    traffic_light_ctrl_param_if.slave   bus
);

    localparam int  PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam bit  HAS_AR = (T_ALLRED > 0);
    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] D_MAIN   = TW'(T_MAIN - 1);
    localparam logic [TW-1:0] D_TURN   = TW'(T_TURN - 1);
    localparam logic [TW-1:0] D_SIDE   = TW'(T_SIDE - 1);
    localparam logic [TW-1:0] D_YEL    = TW'(T_YEL - 1);
    localparam logic [TW-1:0] D_ALLRED = TW'(HAS_AR ? T_ALLRED - 1 : 0);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    generate
        if (TICK_DIV < 1 || T_MAIN < 1 || T_TURN < 1 || T_SIDE < 1 ||
            T_YEL < 1 || T_ALLRED < 0 || TW < 1) begin : g_bad_param
            $error("traffic_light_ctrl_param: illegal timing parameter");
        end
        if (longint'(T_MAIN) > (longint'(1) << TW) || longint'(T_TURN) > (longint'(1) << TW) ||
            longint'(T_SIDE) > (longint'(1) << TW) || longint'(T_YEL) > (longint'(1) << TW) ||
            longint'(T_ALLRED) > (longint'(1) << TW)) begin : g_bad_width
            $error("traffic_light_ctrl_param: duration does not fit in TW bits");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_P0     = 3'd0,
        ST_P1     = 3'd1,
        ST_P2     = 3'd2,
        ST_P3     = 3'd3,
        ST_P4     = 3'd4,
        ST_P5     = 3'd5,
        ST_ALLRED = 3'd6,
        ST_FLASH  = 3'd7
    } state_t;

    // Where ALLRED goes on expiry; T1 defers the side/skip decision to that moment.
    typedef enum logic [1:0] {
        TG_T1    = 2'd0,
        TG_P0    = 2'd1,
        TG_FLASH = 2'd2
    } tgt_t;

    state_t          r_state;
    tgt_t            r_tgt;
    logic [TW-1:0]   r_timer;
    logic [PW-1:0]   r_presc;
    logic            r_pend;
    logic            r_blink;

    state_t          w_state_nxt;
    tgt_t            w_tgt_nxt;
    state_t          w_side_dst;
    logic            w_tick;
    logic            w_expire;
    logic            w_enter;
    logic [2:0]      w_m1, w_m2, w_mt, w_s;

    function automatic logic [TW-1:0] dur_of(state_t s);
        case (s)
            ST_P0:     return D_MAIN;
            ST_P2:     return D_TURN;
            ST_P4:     return D_SIDE;
            ST_P1,
            ST_P3,
            ST_P5:     return D_YEL;
            ST_ALLRED: return D_ALLRED;
            default:   return '0;
        endcase
    endfunction

    assign w_tick   = (r_presc == PRE_MAX);
    assign w_expire = w_tick && (r_timer == '0);

    always_comb begin
        w_side_dst  = (r_pend || (SKIP_SIDE == 0)) ? ST_P4 : ST_P0;
        w_state_nxt = r_state;
        w_tgt_nxt   = r_tgt;
        case (r_state)
            ST_P0: if (w_expire) w_state_nxt = ST_P1;
            ST_P1: if (w_expire) w_state_nxt = ST_P2;
            ST_P2: if (w_expire) w_state_nxt = ST_P3;
            ST_P4: if (w_expire) w_state_nxt = ST_P5;
            ST_P3: if (w_expire) begin
                if (bus.flash_en) begin
                    w_tgt_nxt   = TG_FLASH;
                    w_state_nxt = HAS_AR ? ST_ALLRED : ST_FLASH;
                end else begin
                    w_tgt_nxt   = TG_T1;
                    w_state_nxt = HAS_AR ? ST_ALLRED : w_side_dst;
                end
            end
            ST_P5: if (w_expire) begin
                if (bus.flash_en) begin
                    w_tgt_nxt   = TG_FLASH;
                    w_state_nxt = HAS_AR ? ST_ALLRED : ST_FLASH;
                end else begin
                    w_tgt_nxt   = TG_P0;
                    w_state_nxt = HAS_AR ? ST_ALLRED : ST_P0;
                end
            end
            ST_ALLRED: if (w_expire) begin
                case (r_tgt)
                    TG_FLASH: w_state_nxt = ST_FLASH;
                    TG_T1:    w_state_nxt = w_side_dst;
                    default:  w_state_nxt = ST_P0;
                endcase
            end
            ST_FLASH: if (w_tick && !bus.flash_en) begin
                w_tgt_nxt   = TG_P0;
                w_state_nxt = HAS_AR ? ST_ALLRED : ST_P0;
            end
            default: ;
        endcase
        w_enter = (w_state_nxt != r_state);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_P0;
            r_tgt   <= TG_T1;
            r_timer <= D_MAIN;
            r_presc <= '0;
            r_pend  <= 1'b0;
            r_blink <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_tgt   <= w_tgt_nxt;
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_enter)
                r_timer <= dur_of(w_state_nxt);
            else if (w_tick && r_timer != '0)
                r_timer <= r_timer - 1'b1;
            // Entering P4 serves the demand; a request in that same cycle is absorbed.
            if (w_enter && w_state_nxt == ST_P4)
                r_pend <= 1'b0;
            else if (bus.side_req)
                r_pend <= 1'b1;
            if (w_enter && w_state_nxt == ST_FLASH)
                r_blink <= 1'b1;
            else if (r_state == ST_FLASH && w_tick)
                r_blink <= ~r_blink;
        end
    end

    always_comb begin
        w_m1 = RED;
        w_m2 = RED;
        w_mt = RED;
        w_s  = RED;
        case (r_state)
            ST_P0: begin w_m1 = GRN; w_m2 = GRN; end
            ST_P1: begin w_m1 = GRN; w_m2 = YEL; end
            ST_P2: begin w_m1 = GRN; w_mt = GRN; end
            ST_P3: begin w_m1 = YEL; w_mt = YEL; end
            ST_P4: w_s = GRN;
            ST_P5: w_s = YEL;
            ST_FLASH: begin
                w_m1 = r_blink ? YEL : 3'b000;
                w_m2 = r_blink ? YEL : 3'b000;
                w_mt = r_blink ? YEL : 3'b000;
                w_s  = r_blink ? RED : 3'b000;
            end
            default: ;
        endcase
    end

    assign bus.light_M1  = w_m1;
    assign bus.light_M2  = w_m2;
    assign bus.light_MT  = w_mt;
    assign bus.light_S   = w_s;
    assign bus.phase     = r_state;
    assign bus.side_pend = r_pend;

    function automatic logic lamp_ok(logic [2:0] l, logic in_flash);
        return $onehot(l) || (l == 3'b000 && in_flash);
    endfunction

    a_lamp_encoding: assert property (@(posedge clk) disable iff (rst)
        lamp_ok(w_m1, r_state == ST_FLASH) && lamp_ok(w_m2, r_state == ST_FLASH) &&
        lamp_ok(w_mt, r_state == ST_FLASH) && lamp_ok(w_s, r_state == ST_FLASH));

    a_side_vs_main: assert property (@(posedge clk) disable iff (rst)
        !((w_s[1:0] != 2'b00) && ((w_m1[1:0] | w_m2[1:0] | w_mt[1:0]) != 2'b00)));

    // Flashing amber on every main head is the intended night aspect, so FLASH is exempt.
    a_mt_m2_conflict: assert property (@(posedge clk) disable iff (rst)
        (r_state != ST_FLASH) |-> !((w_mt != RED) && (w_m2 != RED)));

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Bench: three controller instances (defaults, side skip, slow tick without
// clearance) checked every cycle against a phase/cycle-count model.
module tb_traffic_light_ctrl_param;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic clk;
    logic rst0, rst1, rst2;
    int   checks = 0;
    int   errors = 0;

    traffic_light_ctrl_param_if if0();
    traffic_light_ctrl_param_if if1();
    traffic_light_ctrl_param_if if2();

    traffic_light_ctrl_param u0 (.clk(clk), .rst(rst0), .bus(if0));
    traffic_light_ctrl_param #(.SKIP_SIDE(1)) u1 (.clk(clk), .rst(rst1), .bus(if1));
    traffic_light_ctrl_param #(.TICK_DIV(4), .T_ALLRED(0)) u2 (.clk(clk), .rst(rst2), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- model ----------------
    typedef struct {
        int ph;
        int rem;     // clk cycles left in the current phase
        bit pend;
        bit blink;
        int tgt;     // 0 = side-or-main, 1 = main, 2 = flash
        int cyc;     // clk cycles since reset, gives the tick position
    } mdl_t;

    mdl_t m[3];
    int   h0[$], h1[$], h2[$];

    function automatic int td(int k);  return (k == 2) ? 4 : 1; endfunction
    function automatic int ta(int k);  return (k == 2) ? 0 : 1; endfunction
    function automatic bit sk(int k);  return (k == 1);         endfunction

    function automatic int dur(int k, int ph);
        int t;
        case (ph)
            0: t = 7;
            2: t = 2;
            4: t = 3;
            1, 3, 5: t = 2;
            6: t = ta(k);
            default: t = 1;
        endcase
        return t * td(k);
    endfunction

    function automatic int resolve(int k, int tgt, bit pend);
        if (tgt == 2) return 7;
        if (tgt == 1) return 0;
        return (pend || !sk(k)) ? 4 : 0;
    endfunction

    function automatic mdl_t step(mdl_t s_in, int k, bit r, bit req, bit fl);
        mdl_t s;
        bit   tick, op;
        int   dst;
        s = s_in;
        if (r) begin
            s.ph = 0; s.rem = dur(k, 0); s.pend = 0; s.blink = 1; s.tgt = 0; s.cyc = 0;
            return s;
        end
        tick  = (s.cyc % td(k)) == td(k) - 1;
        s.cyc = s.cyc + 1;
        op    = s.pend;
        s.pend = s.pend | req;
        dst   = -1;
        if (s.ph == 7) begin
            if (tick) begin
                if (!fl) begin s.tgt = 1; dst = (ta(k) > 0) ? 6 : 0; end
                else s.blink = !s.blink;
            end
        end else if (s.rem > 1) begin
            s.rem = s.rem - 1;
        end else begin
            if (s.ph == 3) s.tgt = fl ? 2 : 0;
            if (s.ph == 5) s.tgt = fl ? 2 : 1;
            if (s.ph == 3 || s.ph == 5) dst = (ta(k) > 0) ? 6 : resolve(k, s.tgt, op);
            else if (s.ph == 6)         dst = resolve(k, s.tgt, op);
            else                        dst = s.ph + 1;
        end
        if (dst >= 0) begin
            s.ph = dst; s.rem = dur(k, dst);
            if (dst == 7) s.blink = 1;
            if (dst == 4) s.pend = 0;
        end
        return s;
    endfunction

    function automatic logic [11:0] exp_lt(int ph, bit blink);
        logic [2:0] m1, m2, mt, sl;
        m1 = R; m2 = R; mt = R; sl = R;
        case (ph)
            0: begin m1 = G; m2 = G; end
            1: begin m1 = G; m2 = Y; end
            2: begin m1 = G; mt = G; end
            3: begin m1 = Y; mt = Y; end
            4: sl = G;
            5: sl = Y;
            7: begin
                m1 = blink ? Y : 3'b000; m2 = m1; mt = m1;
                sl = blink ? R : 3'b000;
            end
            default: ;
        endcase
        return {m1, m2, mt, sl};
    endfunction

    task automatic cmp(string nm, int k, logic [2:0] ph, logic [11:0] lt, logic pend);
        logic [11:0] el;
        el = exp_lt(m[k].ph, m[k].blink);
        checks++;
        if (int'(ph) != m[k].ph || lt !== el || pend !== m[k].pend) begin
            errors++;
            if (errors < 20)
                $display("FAIL %s @%0t: phase %0d want %0d, lights %h want %h, side_pend %b want %b",
                         nm, $time, ph, m[k].ph, lt, el, pend, m[k].pend);
        end
    endtask

    // Single compare process: advance the model on the edge, check on the falling edge.
    initial begin
        forever begin
            @(posedge clk);
            m[0] = step(m[0], 0, rst0, if0.side_req, if0.flash_en);
            m[1] = step(m[1], 1, rst1, if1.side_req, if1.flash_en);
            m[2] = step(m[2], 2, rst2, if2.side_req, if2.flash_en);
            @(negedge clk);
            cmp("model_u0", 0, if0.phase, {if0.light_M1, if0.light_M2, if0.light_MT, if0.light_S}, if0.side_pend);
            cmp("model_u1", 1, if1.phase, {if1.light_M1, if1.light_M2, if1.light_MT, if1.light_S}, if1.side_pend);
            cmp("model_u2", 2, if2.phase, {if2.light_M1, if2.light_M2, if2.light_MT, if2.light_S}, if2.side_pend);
            if (!rst0) h0.push_back(int'(if0.phase));
            if (!rst1) h1.push_back(int'(if1.phase));
            if (!rst2) h2.push_back(int'(if2.phase));
        end
    end

    // ---------------- directed checks ----------------
    task automatic check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_runs(string nm, input int q[$], input int n,
                            input int eph[12], input int elen[12]);
        int rp[$], rl[$];
        foreach (q[i]) begin
            if (rp.size() == 0 || rp[rp.size()-1] != q[i]) begin
                rp.push_back(q[i]); rl.push_back(1);
            end else begin
                rl[rl.size()-1] = rl[rl.size()-1] + 1;
            end
        end
        check($sformatf("%s_enough_runs", nm), int'(rp.size() > n), 1);
        for (int i = 0; i < n && i < rp.size(); i++) begin
            check($sformatf("%s_run%0d_phase", nm, i), rp[i], eph[i]);
            check($sformatf("%s_run%0d_len", nm, i), rl[i], elen[i]);
        end
    endtask

    initial begin
        int n;
        rst0 = 1; rst1 = 1; rst2 = 1;
        if0.side_req = 0; if0.flash_en = 0;
        if1.side_req = 0; if1.flash_en = 0;
        if2.side_req = 0; if2.flash_en = 0;
        cyc(2);
        check("rst_phase", int'(if0.phase), 0);
        check("rst_M1", int'(if0.light_M1), 1);
        check("rst_M2", int'(if0.light_M2), 1);
        check("rst_MT", int'(if0.light_MT), 4);
        check("rst_S", int'(if0.light_S), 4);
        check("rst_pend", int'(if0.side_pend), 0);
        check("rst_u2_phase", int'(if2.phase), 0);
        rst0 = 0; rst1 = 0; rst2 = 0;

        // Free run: default sequence, and the side-skip sequence without demand.
        cyc(60);
        chk_runs("u0_seq", h0, 10, '{0,1,2,3,6,4,5,6,0,1,0,0}, '{7,2,2,2,1,3,2,1,7,2,0,0});
        chk_runs("u1_skip", h1, 11, '{0,1,2,3,6,0,1,2,3,6,0,0}, '{7,2,2,2,1,7,2,2,2,1,7,0});

        // Side demand pulse on the skipping instance.
        n = 0;
        while (if1.phase != 3'd0 && n < 30) begin cyc(1); n++; end
        check("u1_wait_p0", int'(n < 30), 1);
        if1.side_req = 1; cyc(1); if1.side_req = 0;
        check("u1_pend_set", int'(if1.side_pend), 1);
        n = 0;
        while (if1.phase != 3'd4 && n < 20) begin cyc(1); n++; end
        check("u1_reach_p4", int'(if1.phase), 4);
        check("u1_pend_clr", int'(if1.side_pend), 0);

        // Flash request during P0 takes effect only after P3 via ALLRED.
        n = 0;
        while (if0.phase != 3'd0 && n < 30) begin cyc(1); n++; end
        check("u0_wait_p0", int'(n < 30), 1);
        if0.flash_en = 1;
        h0.delete();
        n = 0;
        while (if0.phase != 3'd7 && n < 40) begin cyc(1); n++; end
        check("fl_enter", int'(if0.phase), 7);
        check("fl_prev_allred", (h0.size() > 1) ? h0[h0.size()-1] : -1, 6);
        check("fl_prev_p3", (h0.size() > 1) ? h0[h0.size()-2] : -1, 3);
        check("fl_went_p2", int'(2 inside {h0}), 1);
        check("fl_M1_on", int'(if0.light_M1), 2);
        check("fl_MT_on", int'(if0.light_MT), 2);
        check("fl_S_on", int'(if0.light_S), 4);
        cyc(1);
        check("fl_M1_off", int'(if0.light_M1), 0);
        check("fl_S_off", int'(if0.light_S), 0);
        cyc(1);
        check("fl_M1_on2", int'(if0.light_M1), 2);
        if0.flash_en = 0;
        cyc(1);
        check("fl_exit_allred", int'(if0.phase), 6);
        check("fl_exit_M1_red", int'(if0.light_M1), 4);
        cyc(1);
        check("fl_exit_p0", int'(if0.phase), 0);

        // Reset in the middle of P4 with a pending demand.
        n = 0;
        while (if0.phase != 3'd4 && n < 30) begin cyc(1); n++; end
        check("u0_reach_p4", int'(if0.phase), 4);
        if0.side_req = 1; cyc(1); if0.side_req = 0;
        check("p4_pend_set", int'(if0.side_pend), 1);
        rst0 = 1; cyc(1); rst0 = 0;
        check("mid_rst_phase", int'(if0.phase), 0);
        check("mid_rst_M1", int'(if0.light_M1), 1);
        check("mid_rst_M2", int'(if0.light_M2), 1);
        check("mid_rst_S", int'(if0.light_S), 4);
        check("mid_rst_pend", int'(if0.side_pend), 0);
        for (int i = 1; i < 7; i++) begin
            cyc(1);
            check($sformatf("mid_rst_p0_cyc%0d", i), int'(if0.phase), 0);
        end
        cyc(1);
        check("mid_rst_p1", int'(if0.phase), 1);

        // Slow tick, no clearance: long phases and P3 straight into P4.
        cyc(20);
        chk_runs("u2_slow", h2, 7, '{0,1,2,3,4,5,0,0,0,0,0,0}, '{28,8,8,8,12,8,28,0,0,0,0,0});
        n = 0;
        foreach (h2[i]) if (h2[i] == 6) n++;
        check("u2_no_allred", n, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl_param.md
Name: traffic_light_ctrl_param

Overview:
Parametrised successor to the four-approach junction controller. It drives main road M1, opposite main M2, main turn MT and side road S. Phase durations and the tick prescaler are set by parameters. New behaviour over the fixed controller: optional all-red clearance, a latched side-road demand with optional side-phase skip, and a night flash mode entered and left only through all-red.

Parameters:
TICK_DIV, 1, clk cycles per timing tick (>=1)
TW, 8, timer width in bits
T_MAIN, 7, ticks for phase P0 (M1+M2 green) (>=1)
T_TURN, 2, ticks for phase P2 (M1+MT green) (>=1)
T_SIDE, 3, ticks for phase P4 (S green) (>=1)
T_YEL, 2, ticks for every yellow phase (>=1)
T_ALLRED, 1, ticks for all-red clearance (0 = clearance state skipped)
SKIP_SIDE, 0, 1 = skip P4/P5 when no side demand is pending

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
side_req  input  1  side-road demand, sampled each clk (pulse or level)
flash_en  input  1  night flash mode request (level)
light_M1  output  3  {R,Y,G} one-hot, bit2=red, bit1=yellow, bit0=green
light_M2  output  3  same encoding
light_MT  output  3  same encoding
light_S  output  3  same encoding
phase  output  3  current state: 0-5 = P0-P5, 6 = ALLRED, 7 = FLASH
side_pend  output  1  latched side demand

Behaviour:
- Reset is synchronous and active-high; all state updates occur on the posedge of clk. On reset: state=P0, prescaler=0, timer=T_MAIN-1, side_pend=0, blink=1. Reset outputs are M1=001, M2=001, MT=100, S=100, phase=0. Reset mid-phase aborts immediately to these values.
- Tick: the prescaler counts 0..TICK_DIV-1, and tick is high in the cycle it equals TICK_DIV-1. With TICK_DIV=1, tick is high every cycle.
- Timer: on entry to any timed state, load duration-1. On each tick, if timer==0 take the transition, else decrement. A state therefore lasts exactly duration*TICK_DIV cycles.
- Lights are decoded combinationally from state. Unlisted lights are red (100).
  - P0: M1 G, M2 G.
  - P1: M1 G, M2 Y.
  - P2: M1 G, MT G.
  - P3: M1 Y, MT Y.
  - P4: S G.
  - P5: S Y.
  - ALLRED: all 100.
  - FLASH: M1, M2 and MT = blink?010:000; S = blink?100:000.
- Transitions at timer expiry:
  - P0->P1.
  - P1->P2.
  - P2->P3.
  - P3->ALLRED (target T1).
  - P5->ALLRED (target T2).
  - P4->P5.
- ALLRED resolves its target on expiry:
  - T1: P4 if (side_pend or !SKIP_SIDE), else P0.
  - T2: P0.
  - If flash_en=1 at P3 or P5 expiry, the target becomes FLASH instead.
- If T_ALLRED=0, ALLRED is bypassed: the target is entered directly at P3/P5 expiry.
- flash_en is honoured only at P3/P5 expiry; assertion in any other state has no effect until then. P1 is never an exit point because M1 is still green.
- FLASH: blink loads 1 on entry and toggles on every tick. When flash_en=0 is seen on a tick, go to ALLRED (target P0), or straight to P0 if T_ALLRED=0.
- side_pend: set when side_req=1 in any cycle, cleared on the cycle P4 is entered. A side_req in the entry cycle is absorbed, i.e. the clear wins. side_pend is retained through FLASH.
- Safety invariants, to be checked by assertions every cycle:
  - Each light is one-hot or 000 (000 only in FLASH).
  - S is never G or Y while any main light is G or Y.
  - MT and M2 are never both non-red.
- The timer never underflows or wraps. Durations must fit in TW bits; an elaboration-time check is required.

Test Plan:
- Reset then free-run with defaults, TICK_DIV=1: phase sequence 0(7 clk),1(2),2(2),3(2),6(1),4(3),5(2),6(1),0. Period is 20 clk.
- SKIP_SIDE=1, side_req never asserted: sequence 0,1,2,3,6,0 with period 14 clk. Then pulse side_req for 1 clk during P0: side_pend=1, the next cycle includes P4, and side_pend=0 from P4 entry.
- TICK_DIV=4, T_ALLRED=0: P0 lasts 28 clk, P3 goes directly to P4, and phase 6 never appears.
- Assert flash_en during P0: no change until P3 expiry. Then ALLRED for 1 clk, then FLASH with M1=010 and S=100 in the first tick, 000 in the next, alternating. Deassert flash_en: ALLRED for 1 clk, then P0.
- Assert rst for 1 clk mid-P4: the next cycle shows phase=0, M1=M2=001, S=100, side_pend=0, and P0 lasts a full 7 clk.
- Throughout all of the above, the safety-invariant assertions never fire.
